// File: rtl/if_id_fetch_stage_pkg.sv
// -----------------------------------------------------------------------------
// if_id_fetch_stage_pkg
// Shared core constants and types for the fetch stage and the decode stage
// that consumes its IF/ID register.
//   CORE_XLEN          : default data/address width
//   CORE_RESET_VECTOR  : default first fetch address after reset
//   CORE_NOP_INSTR     : bubble instruction (addi x0,x0,0)
//   if_id_t            : {pc, instr, valid} as seen by decode
// -----------------------------------------------------------------------------
package if_id_fetch_stage_pkg;

   localparam int               CORE_XLEN         = 32;
   localparam logic [31:0]      CORE_RESET_VECTOR = 32'h0000_0000;
   localparam logic [31:0]      CORE_NOP_INSTR    = 32'h0000_0013;

   typedef struct packed {
      logic [CORE_XLEN-1:0] pc;
      logic [31:0]          instr;
      logic                 valid;
   } if_id_t;

endpackage

// File: rtl/if_id_fetch_stage_skid_buffer.sv
// -----------------------------------------------------------------------------
// fetch_skid_buffer
// One-entry hold register that parks an instruction-memory response which
// arrives while the IF/ID register is frozen, so it is neither lost nor
// fetched twice.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   clear                 : drop the entry (release into IF/ID, or flush)
//   capture               : store cap_pc/cap_instr if the entry is empty
//   cap_pc, cap_instr     : response being parked
//   hold_valid/pc/instr   : current entry
// -----------------------------------------------------------------------------
module fetch_skid_buffer
   import if_id_fetch_stage_pkg::*;
#(
   parameter int XLEN = CORE_XLEN
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            clear,
   input  logic            capture,
   input  logic [XLEN-1:0] cap_pc,
   input  logic [31:0]     cap_instr,
   output logic            hold_valid,
   output logic [XLEN-1:0] hold_pc,
   output logic [31:0]     hold_instr
);

   logic            valid_q, valid_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [31:0]     instr_q, instr_d;

   // Clear wins over capture: a flush or release must never leave a
   // stale entry behind.
   always_comb begin
      valid_d = valid_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      if (clear) begin
         valid_d = 1'b0;
      end else if (capture && !valid_q) begin
         valid_d = 1'b1;
         pc_d    = cap_pc;
         instr_d = cap_instr;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= 1'b0;
         pc_q    <= '0;
         instr_q <= '0;
      end else begin
         valid_q <= valid_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
      end
   end

   assign hold_valid = valid_q;
   assign hold_pc    = pc_q;
   assign hold_instr = instr_q;

endmodule

// File: rtl/if_id_fetch_stage.sv
// -----------------------------------------------------------------------------
// if_id_fetch_stage
// Fetch stage plus IF/ID pipeline register. Owns the PC, issues requests to a
// synchronous instruction memory (1-cycle read latency) and presents
// {pc, instr, valid} to decode. Honours PC-hold / IF/ID-hold from the hazard
// unit without losing or duplicating instructions; squashes on EX redirects.
// Ports:
//   clk, reset                   : clock, synchronous active-high reset
//   PCWrite                      : 0 = hold PC, issue no fetch
//   IF_Dwrite                    : 0 = hold IF/ID contents
//   branch_taken, branch_target  : EX redirect (target bits [1:0] ignored)
//   imem_en, imem_addr           : request issued this cycle
//   imem_rdata                   : data for last cycle's request
//   if_id_pc/instr/valid         : IF/ID register to decode
//   stall_cycles, flush_count    : saturating perf counters, only present
//                                  when FETCH_PERF_EN is defined
// -----------------------------------------------------------------------------
module if_id_fetch_stage
   import if_id_fetch_stage_pkg::*;
#(
   parameter int               XLEN         = CORE_XLEN,
   parameter logic [XLEN-1:0]  RESET_VECTOR = CORE_RESET_VECTOR,
   parameter logic [31:0]      NOP_INSTR    = CORE_NOP_INSTR
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            PCWrite,
   input  logic            IF_Dwrite,
   input  logic            branch_taken,
   input  logic [XLEN-1:0] branch_target,
   output logic            imem_en,
   output logic [XLEN-1:0] imem_addr,
   input  logic [31:0]     imem_rdata,
   output logic [XLEN-1:0] if_id_pc,
   output logic [31:0]     if_id_instr,
`ifdef FETCH_PERF_EN
   output logic [31:0]     stall_cycles,
   output logic [31:0]     flush_count,
`endif
   output logic            if_id_valid
);

   logic [XLEN-1:0] pc_q, pc_d;
   logic            resp_valid_q, resp_valid_d;
   logic [XLEN-1:0] resp_pc_q, resp_pc_d;
   logic            if_valid_q, if_valid_d;
   logic [XLEN-1:0] if_pc_q, if_pc_d;
   logic [31:0]     if_instr_q, if_instr_d;

   logic            hold_valid;
   logic [XLEN-1:0] hold_pc;
   logic [31:0]     hold_instr;
   logic            hold_clear;
   logic            hold_capture;

   logic            src_valid;
   logic [XLEN-1:0] src_pc;
   logic [31:0]     src_instr;

   // Redirect targets are word aligned; the low bits carry no information.
   logic            unused_target_lsbs;
   assign unused_target_lsbs = ^branch_target[1:0];

   assign imem_en   = PCWrite & ~branch_taken;
   assign imem_addr = pc_q;

   // A parked response is always older than the one on imem_rdata, so it
   // goes to decode first.
   always_comb begin
      src_valid = hold_valid | resp_valid_q;
      src_pc    = hold_valid ? hold_pc    : resp_pc_q;
      src_instr = hold_valid ? hold_instr : imem_rdata;
   end

   always_comb begin
      pc_d         = pc_q;
      resp_valid_d = imem_en;
      resp_pc_d    = pc_q;
      if_valid_d   = if_valid_q;
      if_pc_d      = if_pc_q;
      if_instr_d   = if_instr_q;
      hold_clear   = 1'b0;
      hold_capture = 1'b0;

      if (branch_taken) begin
         pc_d = {branch_target[XLEN-1:2], 2'b00};
      end else if (PCWrite) begin
         pc_d = pc_q + XLEN'(4);
      end

      if (branch_taken) begin
         // Squash: whatever is in flight belongs to the wrong path.
         // resp_valid_d is already 0 because imem_en is suppressed.
         if_valid_d = 1'b0;
         if_instr_d = NOP_INSTR;
         hold_clear = 1'b1;
      end else if (IF_Dwrite) begin
         if_valid_d = src_valid;
         if_pc_d    = src_valid ? src_pc : if_pc_q;
         if_instr_d = src_valid ? src_instr : NOP_INSTR;
         hold_clear = 1'b1;
      end else begin
         // IF/ID frozen: park the response that would otherwise vanish.
         hold_capture = resp_valid_q & ~hold_valid;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q         <= RESET_VECTOR;
         resp_valid_q <= 1'b0;
         resp_pc_q    <= RESET_VECTOR;
         if_valid_q   <= 1'b0;
         if_pc_q      <= RESET_VECTOR;
         if_instr_q   <= NOP_INSTR;
      end else begin
         pc_q         <= pc_d;
         resp_valid_q <= resp_valid_d;
         resp_pc_q    <= resp_pc_d;
         if_valid_q   <= if_valid_d;
         if_pc_q      <= if_pc_d;
         if_instr_q   <= if_instr_d;
      end
   end

   fetch_skid_buffer #(.XLEN(XLEN)) u_skid (
      .clk        (clk),
      .reset      (reset),
      .clear      (hold_clear),
      .capture    (hold_capture),
      .cap_pc     (resp_pc_q),
      .cap_instr  (imem_rdata),
      .hold_valid (hold_valid),
      .hold_pc    (hold_pc),
      .hold_instr (hold_instr)
   );

   assign if_id_pc    = if_pc_q;
   assign if_id_instr = if_instr_q;
   assign if_id_valid = if_valid_q;

   // A second response while the entry is occupied would be dropped. The
   // hazard unit drives PCWrite == IF_Dwrite, which makes this impossible.
   a_no_skid_overflow: assert property (@(posedge clk) disable iff (reset)
      !(resp_valid_q && hold_valid && !IF_Dwrite && !branch_taken));

`ifdef FETCH_PERF_EN
   logic [31:0] stall_cycles_q, stall_cycles_d;
   logic [31:0] flush_count_q, flush_count_d;

   always_comb begin
      stall_cycles_d = stall_cycles_q;
      flush_count_d  = flush_count_q;
      if (!IF_Dwrite && !branch_taken && stall_cycles_q != 32'hFFFF_FFFF) begin
         stall_cycles_d = stall_cycles_q + 32'd1;
      end
      if (branch_taken && flush_count_q != 32'hFFFF_FFFF) begin
         flush_count_d = flush_count_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cycles_q <= '0;
         flush_count_q  <= '0;
      end else begin
         stall_cycles_q <= stall_cycles_d;
         flush_count_q  <= flush_count_d;
      end
   end

   assign stall_cycles = stall_cycles_q;
   assign flush_count  = flush_count_q;
`endif

endmodule

// File: tb/tb_if_id_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_if_id_fetch_stage
// Bench for if_id_fetch_stage. Memory model returns the request address as
// data (random garbage when no request was made). A reference model tracks
// the fetch stream as a queue of issued-but-not-yet-decoded addresses.
// -----------------------------------------------------------------------------
module tb_if_id_fetch_stage;

   localparam logic [31:0] RV  = 32'h0000_0000;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        PCWrite = 1'b1;
   logic        IF_Dwrite = 1'b1;
   logic        branch_taken = 1'b0;
   logic [31:0] branch_target = 32'h0;
   logic        imem_en;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata = 32'h0;
   logic [31:0] if_id_pc;
   logic [31:0] if_id_instr;
   logic        if_id_valid;
`ifdef FETCH_PERF_EN
   logic [31:0] stall_cycles;
   logic [31:0] flush_count;
`endif

   int tests_run = 0;
   int fails = 0;
   int cyc = 0;

   // reference model state
   logic [31:0] m_q[$];
   logic [31:0] m_pc = RV;
   logic [31:0] m_ifpc = RV;
   logic [31:0] m_instr = NOP;
   logic        m_valid = 1'b0;
   logic [31:0] m_stall = 32'h0;
   logic [31:0] m_flush = 32'h0;

   if_id_fetch_stage dut (
      .clk           (clk),
      .reset         (reset),
      .PCWrite       (PCWrite),
      .IF_Dwrite     (IF_Dwrite),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .imem_en       (imem_en),
      .imem_addr     (imem_addr),
      .imem_rdata    (imem_rdata),
      .if_id_pc      (if_id_pc),
      .if_id_instr   (if_id_instr),
`ifdef FETCH_PERF_EN
      .stall_cycles  (stall_cycles),
      .flush_count   (flush_count),
`endif
      .if_id_valid   (if_id_valid)
   );

   always #5 clk = ~clk;

   always @(posedge clk) imem_rdata <= imem_en ? imem_addr : $urandom;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Expected / observed views: {imem_en, imem_addr, valid, pc, instr}.
   // pc is only meaningful while valid.
   function automatic logic [97:0] exp_vec();
      return {PCWrite & ~branch_taken, m_pc, m_valid, m_valid ? m_ifpc : 32'h0, m_instr};
   endfunction

   function automatic logic [97:0] act_vec();
      return {imem_en, imem_addr, if_id_valid, m_valid ? if_id_pc : 32'h0, if_id_instr};
   endfunction

   // Advance the model by one clock using the current inputs, then clock the DUT.
   task automatic step();
      if (reset) begin
         m_q.delete();
         m_valid = 1'b0; m_instr = NOP; m_ifpc = RV; m_pc = RV;
         m_stall = 32'h0; m_flush = 32'h0;
      end else if (branch_taken) begin
         m_q.delete();
         m_valid = 1'b0; m_instr = NOP;
         m_pc = {branch_target[31:2], 2'b00};
         if (m_flush != 32'hFFFF_FFFF) m_flush++;
      end else begin
         if (IF_Dwrite) begin
            if (m_q.size() > 0) begin
               m_ifpc = m_q.pop_front(); m_instr = m_ifpc; m_valid = 1'b1;
            end else begin
               m_valid = 1'b0; m_instr = NOP;
            end
         end else if (m_stall != 32'hFFFF_FFFF) begin
            m_stall++;
         end
         if (PCWrite) begin
            m_q.push_back(m_pc);
            m_pc = m_pc + 32'd4;
         end
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
   endtask

   // Fresh start, run until pc 8 sits in IF/ID (ends on a negedge).
   task automatic goto_pc8();
      reset = 1'b1; PCWrite = 1'b1; IF_Dwrite = 1'b1; branch_taken = 1'b0;
      step();
      reset = 1'b0;
      for (int i = 0; i < 10 && !(m_valid && m_ifpc == 32'h8); i++) step();
   endtask

   task automatic test_reset();
      reset = 1'b1; PCWrite = 1'b1; IF_Dwrite = 1'b1; branch_taken = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step(); #1;
         tests_run++;
         if (if_id_valid !== 1'b0 || if_id_instr !== NOP || imem_addr !== RV) begin
            fails++;
            $display("FAIL reset_hold cyc=%0d: got valid=%0b instr=%h addr=%h, exp 0 %h %h",
                     cyc, if_id_valid, if_id_instr, imem_addr, NOP, RV);
         end
      end
      reset = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #1;
         tests_run++;
         if (imem_en !== 1'b1 || imem_addr !== 32'(4 * k) || if_id_valid !== (k == 2)) begin
            fails++;
            $display("FAIL reset_release k=%0d: got en=%0b addr=%h valid=%0b, exp 1 %h %0b",
                     k, imem_en, imem_addr, if_id_valid, 32'(4 * k), (k == 2));
         end
         tests_run++;
         if (act_vec() !== exp_vec()) begin
            fails++;
            $display("FAIL reset_model cyc=%0d: got %h, exp %h", cyc, act_vec(), exp_vec());
         end
         if (k < 2) step();
      end
      tests_run++;
      if (if_id_pc !== 32'h0 || if_id_instr !== 32'h0) begin
         fails++;
         $display("FAIL first_instr: got pc=%h instr=%h, exp 0 0", if_id_pc, if_id_instr);
      end
   endtask

   task automatic test_straight_line();
      for (int k = 1; k < 8; k++) begin
         step(); #1;
         tests_run++;
         if (if_id_valid !== 1'b1 || if_id_pc !== 32'(4 * k) || if_id_instr !== 32'(4 * k)) begin
            fails++;
            $display("FAIL straight k=%0d: got valid=%0b pc=%h instr=%h, exp 1 %h %h",
                     k, if_id_valid, if_id_pc, if_id_instr, 32'(4 * k), 32'(4 * k));
         end
         tests_run++;
         if (act_vec() !== exp_vec()) begin
            fails++;
            $display("FAIL straight_model cyc=%0d: got %h, exp %h", cyc, act_vec(), exp_vec());
         end
      end
   endtask

   task automatic test_stall_single();
      logic [31:0] exp_pc [4] = '{32'h8, 32'h8, 32'hC, 32'h10};
      logic        stall  [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
      goto_pc8();
      for (int i = 0; i < 4; i++) begin
         PCWrite = !stall[i]; IF_Dwrite = !stall[i];
         #1;
         tests_run++;
         if (if_id_valid !== 1'b1 || if_id_pc !== exp_pc[i]) begin
            fails++;
            $display("FAIL stall1 i=%0d: got valid=%0b pc=%h, exp 1 %h",
                     i, if_id_valid, if_id_pc, exp_pc[i]);
         end
         tests_run++;
         if (act_vec() !== exp_vec()) begin
            fails++;
            $display("FAIL stall1_model cyc=%0d: got %h, exp %h", cyc, act_vec(), exp_vec());
         end
         if (i < 3) step();
      end
   endtask

   task automatic test_stall_three();
      logic [31:0] exp_pc [7] = '{32'h8, 32'h8, 32'h8, 32'h8, 32'hC, 32'h10, 32'h14};
      logic        stall  [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      goto_pc8();
      for (int i = 0; i < 7; i++) begin
         PCWrite = !stall[i]; IF_Dwrite = !stall[i];
         #1;
         tests_run++;
         if (if_id_valid !== 1'b1 || if_id_pc !== exp_pc[i] || if_id_instr !== exp_pc[i]) begin
            fails++;
            $display("FAIL stall3 i=%0d: got valid=%0b pc=%h instr=%h, exp 1 %h %h",
                     i, if_id_valid, if_id_pc, if_id_instr, exp_pc[i], exp_pc[i]);
         end
         tests_run++;
         if (act_vec() !== exp_vec()) begin
            fails++;
            $display("FAIL stall3_model cyc=%0d: got %h, exp %h", cyc, act_vec(), exp_vec());
         end
         if (i < 6) step();
      end
`ifdef FETCH_PERF_EN
      tests_run++;
      if (stall_cycles !== 32'd3) begin
         fails++;
         $display("FAIL stall3_perf: got stall_cycles=%0d, exp 3", stall_cycles);
      end
`endif
   endtask

   task automatic test_branch();
      goto_pc8();
      PCWrite = 1'b0; IF_Dwrite = 1'b0;
      #1;
      tests_run++;
      if (act_vec() !== exp_vec()) begin
         fails++;
         $display("FAIL branch_pre_model cyc=%0d: got %h, exp %h", cyc, act_vec(), exp_vec());
      end
      step();
      branch_taken = 1'b1; branch_target = 32'h103;
      #1;
      tests_run++;
      if (imem_en !== 1'b0) begin
         fails++;
         $display("FAIL branch_en: got imem_en=%0b, exp 0", imem_en);
      end
      step();
      branch_taken = 1'b0; PCWrite = 1'b1; IF_Dwrite = 1'b1;
      #1;
      tests_run++;
      if (if_id_valid !== 1'b0 || if_id_instr !== NOP || imem_addr !== 32'h100 || imem_en !== 1'b1) begin
         fails++;
         $display("FAIL branch_flush: got valid=%0b instr=%h addr=%h en=%0b, exp 0 %h 00000100 1",
                  if_id_valid, if_id_instr, imem_addr, imem_en, NOP);
      end
      for (int i = 0; i < 2; i++) begin
         step(); #1;
         tests_run++;
         if (act_vec() !== exp_vec()) begin
            fails++;
            $display("FAIL branch_model cyc=%0d: got %h, exp %h", cyc, act_vec(), exp_vec());
         end
      end
      tests_run++;
      if (if_id_valid !== 1'b1 || if_id_pc !== 32'h100 || if_id_instr !== 32'h100) begin
         fails++;
         $display("FAIL branch_target: got valid=%0b pc=%h instr=%h, exp 1 00000100 00000100",
                  if_id_valid, if_id_pc, if_id_instr);
      end
`ifdef FETCH_PERF_EN
      tests_run++;
      if (flush_count !== 32'd1) begin
         fails++;
         $display("FAIL branch_perf: got flush_count=%0d, exp 1", flush_count);
      end
`endif
   endtask

   task automatic test_reset_mid_stall();
      goto_pc8();
      PCWrite = 1'b0; IF_Dwrite = 1'b0;
      step();              // hold buffer now parks pc 0xC
      step();
      reset = 1'b1;
      #1;
      step(); #1;
      tests_run++;
      if (if_id_valid !== 1'b0 || if_id_instr !== NOP) begin
         fails++;
         $display("FAIL rst_stall_bubble: got valid=%0b instr=%h, exp 0 %h",
                  if_id_valid, if_id_instr, NOP);
      end
      reset = 1'b0; PCWrite = 1'b1; IF_Dwrite = 1'b1;
      for (int k = 0; k < 3; k++) begin
         #1;
         tests_run++;
         if (imem_addr !== 32'(4 * k) || if_id_valid !== (k == 2) ||
             (k == 2 && if_id_pc !== 32'h0)) begin
            fails++;
            $display("FAIL rst_stall_restart k=%0d: got addr=%h valid=%0b pc=%h, exp %h %0b 0",
                     k, imem_addr, if_id_valid, if_id_pc, 32'(4 * k), (k == 2));
         end
         tests_run++;
         if (act_vec() !== exp_vec()) begin
            fails++;
            $display("FAIL rst_stall_model cyc=%0d: got %h, exp %h", cyc, act_vec(), exp_vec());
         end
         if (k < 2) step();
      end
   endtask

   task automatic test_random();
      int unsigned r;
      logic        stl;
      goto_pc8();
      for (int i = 0; i < 400; i++) begin
         r   = $urandom_range(0, 99);
         stl = ($urandom_range(0, 99) < 30);
         reset         = (r < 2);
         branch_taken  = (r >= 2 && r < 9);
         branch_target = $urandom;
         PCWrite       = !stl;
         IF_Dwrite     = !stl;
         #1;
         tests_run++;
         if (act_vec() !== exp_vec()) begin
            fails++;
            $display("FAIL random_model cyc=%0d: got %h, exp %h", cyc, act_vec(), exp_vec());
         end
         step();
      end
      reset = 1'b0; branch_taken = 1'b0; PCWrite = 1'b1; IF_Dwrite = 1'b1;
      #1;
      tests_run++;
      if (act_vec() !== exp_vec()) begin
         fails++;
         $display("FAIL random_end cyc=%0d: got %h, exp %h", cyc, act_vec(), exp_vec());
      end
`ifdef FETCH_PERF_EN
      tests_run++;
      if (stall_cycles !== m_stall || flush_count !== m_flush) begin
         fails++;
         $display("FAIL random_perf: got stall=%0d flush=%0d, exp %0d %0d",
                  stall_cycles, flush_count, m_stall, m_flush);
      end
`endif
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_straight_line();
      test_stall_single();
      test_stall_three();
      test_branch();
      test_reset_mid_stall();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end

endmodule
